// File: rtl/note_scroll_controller.sv
// note_scroll_controller
// Sequences the three-lane note shift register: divides clk into a one-cycle
// slow_clk tick, holds load_n high across the first tick so the shifter
// latches the song image, then counts SONG_LEN ticks of scrolling.
// Optional feature: define NOTE_CTRL_PAUSE_EN to let `pause` freeze the
// divider while playing; otherwise `pause` is ignored.
module note_scroll_controller #(
  parameter int CLK_DIV  = 5000000,
  parameter int SONG_LEN = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [1:0] song_in,
  output logic       slow_clk,
  output logic       load_n,
  output logic [1:0] song_sel,
  output logic [6:0] beat_count,
  output logic       playing,
  output logic       done
);

  localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]      LAST_BEAT = 7'(SONG_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] div;
  logic             pause_eff;
  logic             div_en;
  logic             accept;

`ifdef NOTE_CTRL_PAUSE_EN
  assign pause_eff = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_eff    = 1'b0;
`endif

  // Divider runs through LOAD and the LOAD->PLAY handoff so the first PLAY
  // tick lands exactly CLK_DIV cycles after the load tick.
  assign div_en = (state == S_LOAD) || ((state == S_PLAY) && !pause_eff);
  assign accept = ((state == S_IDLE) || (state == S_DONE)) && start && !stop;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state: slow_clk is registered, so a high slow_clk here means this
  // edge is the one ending the tick pulse.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (slow_clk) state_d = S_PLAY;
      S_PLAY:  if (slow_clk && (beat_count == LAST_BEAT)) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
    if (stop) state_d = S_IDLE;
  end

  // Divider, tick pulse and registered status outputs. load_n follows the
  // next state, so it only changes while slow_clk is low or on the edge that
  // ends a pulse -- never on a slow_clk rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      div      <= '0;
      slow_clk <= 1'b0;
      load_n   <= 1'b0;
      playing  <= 1'b0;
      done     <= 1'b0;
    end else begin
      if ((state_d == S_IDLE) || (state_d == S_DONE))
        div <= '0;
      else if (div_en)
        div <= (div == DIV_MAX) ? '0 : div + 1'b1;
      slow_clk <= !stop && div_en && (div == DIV_MAX);
      load_n   <= (state_d == S_LOAD);
      playing  <= (state_d == S_PLAY);
      done     <= (state_d == S_DONE);
    end
  end

  // Song select capture; held through stop, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)       song_sel <= 2'd0;
    else if (accept) song_sel <= song_in;
  end

  // Beat counter: cleared when the load tick ends, bumped as each PLAY tick
  // ends, held in DONE (it stops at SONG_LEN because DONE has no ticks).
  always_ff @(posedge clk) begin
    if (reset || stop) begin
      beat_count <= 7'd0;
    end else if (slow_clk) begin
      if (state == S_LOAD)      beat_count <= 7'd0;
      else if (state == S_PLAY) beat_count <= beat_count + 7'd1;
    end
  end

endmodule

// File: tb/tb_note_scroll_controller.sv
// Bench for note_scroll_controller (CLK_DIV=4, SONG_LEN=8). A timeline model
// counts active divider cycles and completed tick pulses since the last
// accepted start; the compare process checks every output each cycle, and the
// directed stimulus pins key latencies with literal values.
module tb_note_scroll_controller;

  localparam int D = 4;
  localparam int L = 8;

  logic       clk = 1'b0;
  logic       reset, start, stop, pause;
  logic [1:0] song_in;
  logic       slow_clk, load_n, playing, done;
  logic [1:0] song_sel;
  logic [6:0] beat_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  note_scroll_controller #(.CLK_DIV(D), .SONG_LEN(L)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .song_in(song_in), .slow_clk(slow_clk), .load_n(load_n),
    .song_sel(song_sel), .beat_count(beat_count), .playing(playing),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

`ifdef NOTE_CTRL_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  // Model: m_np = tick pulses completed since start (0 = loading,
  // 1..L = playing, L+1 = done); m_eff = divider-active cycles since start.
  bit         m_on   = 1'b0;
  int         m_eff  = 0;
  int         m_np   = 0;
  int         m_beat = 0;
  bit         m_sclk = 1'b0;
  logic [1:0] m_song = 2'd0;
  bit         m_act;

  always @(posedge clk) begin
    if (reset) begin
      m_on = 0; m_eff = 0; m_np = 0; m_sclk = 0; m_beat = 0; m_song = 2'd0;
    end else if (stop) begin
      m_on = 0; m_eff = 0; m_np = 0; m_sclk = 0; m_beat = 0;
    end else if ((!m_on || m_np == L + 1) && start) begin
      m_on = 1; m_eff = 0; m_np = 0; m_sclk = 0; m_song = song_in;
    end else if (m_on && m_np <= L) begin
      m_act = (m_np == 0) || !(PAUSE_ON && pause);
      if (m_sclk) begin
        m_np++;
        m_beat = m_np - 1;
      end
      if (m_np == L + 1) m_sclk = 0;
      else if (m_act) begin
        m_eff++;
        m_sclk = (m_eff % D == 0);
      end else m_sclk = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("slow_clk",   slow_clk,   m_sclk);
      check("load_n",     load_n,     m_on && m_np == 0);
      check("playing",    playing,    m_on && m_np >= 1 && m_np <= L);
      check("done",       done,       m_on && m_np == L + 1);
      check("song_sel",   song_sel,   m_song);
      check("beat_count", beat_count, m_beat);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int cyc, pulses, loads;

  initial begin
    reset = 1; start = 0; stop = 0; pause = 0; song_in = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("rst_load_n", load_n, 0);
    check("rst_slow_clk", slow_clk, 0);
    check("rst_beat", beat_count, 0);
    reset = 0;

    // Start-to-load latency with song 2
    start = 1; song_in = 2;
    @(negedge clk); start = 0; song_in = 0;
    check("t1_song_sel", song_sel, 2);
    check("t1_load_n", load_n, 1);
    repeat (3) @(negedge clk);
    check("t1_sclk_before", slow_clk, 0);
    @(negedge clk);
    check("t1_sclk_edge4", slow_clk, 1);
    check("t1_load_held", load_n, 1);
    @(negedge clk);
    check("t1_load_n_edge5", load_n, 0);
    check("t1_playing", playing, 1);

    // Uninterrupted play to DONE
    cyc = 0; pulses = 0;
    while (!done && cyc < 200) begin
      @(negedge clk); cyc++;
      if (slow_clk) pulses++;
    end
    check("t2_cycles_to_done", cyc, L * D);
    check("t2_pulses", pulses, L);
    check("t2_beat", beat_count, L);
    pulses = 0;
    repeat (12) begin @(negedge clk); if (slow_clk) pulses++; end
    check("t2_no_pulse_after_done", pulses, 0);
    check("t2_done_held", done, 1);

    // Restart from DONE with song 1, then pause mid-PLAY
    start = 1; song_in = 1;
    @(negedge clk); start = 0;
    check("t3_done_clear", done, 0);
    check("t3_load_n", load_n, 1);
    check("t3_song_sel", song_sel, 1);
    cyc = 0;
    while (!playing && cyc < 50) begin @(negedge clk); cyc++; end
    check("t3_play_latency", cyc, D + 1);
    cyc = 0;
    while (beat_count != 3 && cyc < 50) begin @(negedge clk); cyc++; end
    check("t3_beat3_latency", cyc, 3 * D);
    pause = 1; start = 1; song_in = 3; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); start = 0;
      if (slow_clk) pulses++;
    end
    pause = 0;
    check("t3_pause_pulses", pulses, PAUSE_ON ? 0 : 2);
    check("t3_pause_beat", beat_count, PAUSE_ON ? 3 : 5);
    check("t3_start_ignored", song_sel, 1);
    cyc = 0;
    while (!slow_clk && cyc < 20) begin @(negedge clk); cyc++; end
    check("t3_resume_latency", cyc, PAUSE_ON ? 3 : 1);

    // Abort, stop beats start in IDLE, then stop on a tick at beat 3
    stop = 1;
    @(negedge clk); stop = 0;
    check("t4_abort_playing", playing, 0);
    check("t4_abort_song", song_sel, 1);
    start = 1; stop = 1; song_in = 2;
    @(negedge clk); stop = 0; start = 0;
    check("t4_stop_prio_load", load_n, 0);
    check("t4_stop_prio_song", song_sel, 1);
    start = 1; song_in = 3;
    @(negedge clk); start = 0;
    cyc = 0;
    while (!(beat_count == 2 && slow_clk) && cyc < 100) begin @(negedge clk); cyc++; end
    check("t4_found_tick", slow_clk, 1);
    stop = 1;
    @(negedge clk); stop = 0;
    check("t4_beat", beat_count, 0);
    check("t4_slow_clk", slow_clk, 0);
    check("t4_load_n", load_n, 0);
    check("t4_song_held", song_sel, 3);

    // Reset during LOAD
    start = 1; song_in = 2;
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    check("t5_in_load", load_n, 1);
    reset = 1;
    @(negedge clk); reset = 0;
    check("t5_song_sel", song_sel, 0);
    check("t5_load_n", load_n, 0);
    check("t5_slow_clk", slow_clk, 0);
    pulses = 0; loads = 0;
    repeat (3 * D) begin
      @(negedge clk);
      if (slow_clk) pulses++;
      if (load_n) loads++;
    end
    check("t5_no_pulses", pulses, 0);
    check("t5_no_load", loads, 0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
